// File: rtl/alu_result_writeback_pkg.sv
// Shared definitions for the ALU result path: opcode encodings, write-port
// selector encodings and the writeback sequencer state type.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [1:0] WR_SEL_GPR = 2'b00;
  localparam logic [1:0] WR_SEL_LO  = 2'b01;
  localparam logic [1:0] WR_SEL_HI  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_GPR,
    ST_WR_LO,
    ST_WR_HI,
    ST_ERR
  } wb_state_t;

endpackage

// File: rtl/alu_result_writeback_op_class.sv
// Combinational opcode classifier: single-word result, double-word (mul/div)
// result, or unsupported. Reusable by the ALU control path.
module alu_op_class
  import alu_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic       o_single,
  output logic       o_double,
  output logic       o_invalid
);

  always_comb begin
    o_single  = 1'b0;
    o_double  = 1'b0;
    o_invalid = 1'b0;
    case (i_opcode)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SHL, OP_SHR,
      OP_SHRA, OP_ROL, OP_ROR, OP_NEG, OP_NOT: o_single  = 1'b1;
      OP_MUL, OP_DIV:                          o_double  = 1'b1;
      default:                                 o_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_result_writeback.sv
// Writeback sequencer: latches one 64-bit ALU result per handshake and drives
// it onto the 32-bit register write port (one GPR write, or LO then HI).
module alu_result_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            opcode,
  input  logic [REG_AW-1:0]     rd,
  input  logic [2*DATA_W-1:0]   result,
  output logic                  wr_en,
  output logic [1:0]            wr_sel,
  output logic [REG_AW-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  done,
  output logic                  op_err
);

  wb_state_t           r_state;
  wb_state_t           w_next_state;
  logic [2*DATA_W-1:0] r_z;
  logic [4:0]          r_opcode;
  logic [REG_AW-1:0]   r_rd;
  logic                w_accept;
  logic                w_is_single;
  logic                w_is_double;
  logic                w_is_invalid;

  alu_op_class u_op_class (
    .i_opcode  (opcode),
    .o_single  (w_is_single),
    .o_double  (w_is_double),
    .o_invalid (w_is_invalid)
  );

  // Only the LO beat of a two-word op blocks the sender; every other state
  // is either idle or a final beat that can overlap the next accept.
  assign in_ready = (r_state != ST_WR_LO);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      // HI follows LO only for a genuine two-word op held in the latch
      ST_WR_LO: w_next_state = (r_opcode == OP_MUL || r_opcode == OP_DIV) ? ST_WR_HI : ST_IDLE;
      default: begin
        if (w_accept) begin
          if (w_is_single)       w_next_state = ST_WR_GPR;
          else if (w_is_double)  w_next_state = ST_WR_LO;
          else if (w_is_invalid) w_next_state = ST_ERR;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state  <= ST_IDLE;
      r_z      <= '0;
      r_opcode <= '0;
      r_rd     <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_z      <= result;
        r_opcode <= opcode;
        r_rd     <= rd;
      end
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_sel  = WR_SEL_GPR;
    wr_addr = '0;
    wr_data = '0;
    done    = 1'b0;
    op_err  = 1'b0;
    case (r_state)
      ST_WR_GPR: begin
        wr_en   = 1'b1;
        wr_addr = r_rd;
        wr_data = r_z[DATA_W-1:0];
        done    = 1'b1;
      end
      ST_WR_LO: begin
        wr_en   = 1'b1;
        wr_sel  = WR_SEL_LO;
        wr_data = r_z[DATA_W-1:0];
      end
      ST_WR_HI: begin
        wr_en   = 1'b1;
        wr_sel  = WR_SEL_HI;
        wr_data = r_z[2*DATA_W-1:DATA_W];
        done    = 1'b1;
      end
      ST_ERR:  op_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Self-checking bench for alu_result_writeback: directed scenarios plus random
// traffic, compared against a queue-of-expected-beats reference model.
module tb_alu_result_writeback;

  logic        clock = 1'b0;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [3:0]  rd;
  logic [63:0] result;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        done;
  logic        op_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        done;
    logic        err;
  } beat_t;

  beat_t expQ[$];

  alu_result_writeback #(.DATA_W(32), .REG_AW(4)) dut (
    .clock    (clock),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .rd       (rd),
    .result   (result),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .done     (done),
    .op_err   (op_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // 0 = invalid, 1 = one GPR write, 2 = LO then HI
  function automatic int opWords(input logic [4:0] op);
    case (op)
      5'd5, 5'd6, 5'd3, 5'd4, 5'd9, 5'd7, 5'd8, 5'd11, 5'd10, 5'd17, 5'd18: return 1;
      5'd15, 5'd16: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic modelReady();
    return expQ.size() <= 1;
  endfunction

  task automatic modelAccept(input logic [4:0] op, input logic [3:0] r, input logic [63:0] res);
    beat_t b;
    case (opWords(op))
      1: begin
        b = '{1'b1, 2'b00, r, res[31:0], 1'b1, 1'b0};
        expQ.push_back(b);
      end
      2: begin
        b = '{1'b1, 2'b01, 4'd0, res[31:0], 1'b0, 1'b0};
        expQ.push_back(b);
        b = '{1'b1, 2'b10, 4'd0, res[63:32], 1'b1, 1'b0};
        expQ.push_back(b);
      end
      default: begin
        b = '{1'b0, 2'b00, 4'd0, 32'd0, 1'b0, 1'b1};
        expQ.push_back(b);
      end
    endcase
  endtask

  task automatic compareAll(input string tag);
    beat_t e;
    e = '{1'b0, 2'b00, 4'd0, 32'd0, 1'b0, 1'b0};
    if (expQ.size() > 0) e = expQ[0];
    checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'(modelReady()));
    checkOutput({tag, ".wr_en"},    64'(wr_en),    64'(e.en));
    checkOutput({tag, ".wr_sel"},   64'(wr_sel),   64'(e.sel));
    checkOutput({tag, ".wr_addr"},  64'(wr_addr),  64'(e.addr));
    checkOutput({tag, ".wr_data"},  64'(wr_data),  64'(e.data));
    checkOutput({tag, ".done"},     64'(done),     64'(e.done));
    checkOutput({tag, ".op_err"},   64'(op_err),   64'(e.err));
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, then
  // advance the model at the rising edge.
  task automatic applyStimulus(input string tag, input logic v, input logic [4:0] op,
                               input logic [3:0] r, input logic [63:0] res, output logic accepted);
    in_valid = v;
    opcode   = op;
    rd       = r;
    result   = res;
    @(negedge clock);
    compareAll(tag);
    accepted = v && modelReady();
    @(posedge clock);
    if (expQ.size() > 0) void'(expQ.pop_front());
    if (accepted) modelAccept(op, r, res);
    #1;
  endtask

  initial begin
    logic acc;
    logic [4:0]  hOp;
    logic [3:0]  hRd;
    logic [63:0] hRes;
    logic        hValid;

    clear = 1'b1; in_valid = 1'b0; opcode = '0; rd = '0; result = '0;
    @(negedge clock);
    checkOutput("reset.wr_en",   64'(wr_en),   64'd0);
    checkOutput("reset.wr_sel",  64'(wr_sel),  64'd0);
    checkOutput("reset.wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("reset.wr_data", 64'(wr_data), 64'd0);
    checkOutput("reset.done",    64'(done),    64'd0);
    checkOutput("reset.op_err",  64'(op_err),  64'd0);
    @(posedge clock); #1;
    clear = 1'b0;

    applyStimulus("add", 1'b1, 5'b00011, 4'd5, 64'h7, acc);
    applyStimulus("addWr", 1'b0, 5'd0, 4'd0, 64'h0, acc);
    applyStimulus("addIdle", 1'b0, 5'd0, 4'd0, 64'h0, acc);

    applyStimulus("mul", 1'b1, 5'b01111, 4'd9, 64'h0000_0001_FFFF_FFFE, acc);
    applyStimulus("mulLo", 1'b0, 5'd0, 4'd0, 64'h0, acc);
    applyStimulus("mulHi", 1'b0, 5'd0, 4'd0, 64'h0, acc);

    applyStimulus("div", 1'b1, 5'b10000, 4'd0, 64'h0000_0001_0000_0003, acc);
    applyStimulus("divLo", 1'b0, 5'd0, 4'd0, 64'h0, acc);
    applyStimulus("divHiOr", 1'b1, 5'b00110, 4'd2, 64'hF0, acc);
    applyStimulus("orWr", 1'b0, 5'd0, 4'd0, 64'h0, acc);

    for (int i = 1; i <= 4; i++)
      applyStimulus("b2bAdd", 1'b1, 5'b00011, 4'(i), 64'(i * 16 + 1), acc);
    applyStimulus("b2bDrain", 1'b0, 5'd0, 4'd0, 64'h0, acc);

    applyStimulus("bad", 1'b1, 5'b11111, 4'd3, 64'h55, acc);
    applyStimulus("errAdd", 1'b1, 5'b00101, 4'd7, 64'hFFFF_FFFF_0000_00A5, acc);
    applyStimulus("errAddWr", 1'b0, 5'd0, 4'd0, 64'h0, acc);

    applyStimulus("mulClr", 1'b1, 5'b01111, 4'd0, 64'hAAAA_BBBB_CCCC_DDDD, acc);
    in_valid = 1'b0;
    #2 clear = 1'b1;
    #1;
    checkOutput("clr.wr_en",   64'(wr_en),   64'd0);
    checkOutput("clr.wr_sel",  64'(wr_sel),  64'd0);
    checkOutput("clr.wr_data", 64'(wr_data), 64'd0);
    checkOutput("clr.done",    64'(done),    64'd0);
    checkOutput("clr.op_err",  64'(op_err),  64'd0);
    expQ.delete();
    @(posedge clock); #1;
    clear = 1'b0;
    applyStimulus("postClr", 1'b0, 5'd0, 4'd0, 64'h0, acc);
    applyStimulus("postClrAdd", 1'b1, 5'b00011, 4'd12, 64'h1234_5678, acc);
    applyStimulus("postClrWr", 1'b0, 5'd0, 4'd0, 64'h0, acc);

    hValid = 1'b0; hOp = '0; hRd = '0; hRes = '0;
    acc = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!(hValid && !acc)) begin
        hValid = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 5))
          0: hOp = 5'($urandom_range(0, 31));
          1, 2: hOp = ($urandom_range(0, 1) != 0) ? 5'b01111 : 5'b10000;
          default: hOp = 5'($urandom_range(3, 11));
        endcase
        hRd  = 4'($urandom_range(0, 15));
        hRes = {32'($urandom), 32'($urandom)};
      end
      applyStimulus("rand", hValid, hOp, hRd, hRes, acc);
    end
    for (int n = 0; n < 3; n++)
      applyStimulus("drain", 1'b0, 5'd0, 4'd0, 64'h0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Consumer end of the ALU result path.
- Accepts one 64-bit ALU result (Z) with its opcode and destination register through a valid/ready handshake, latches it, then sequences it onto the single 32-bit write port.
- Single-word ops write one GPR. Multiply and divide write LO then HI over two cycles.
- Sits between the ALU and the register file / HI / LO registers.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W
REG_AW, 4, GPR address width (16 registers)

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous active-high reset
in_valid  input  1  result/opcode/rd valid this cycle
in_ready  output  1  block can accept this cycle
opcode  input  5  ALU opcode that produced result
rd  input  REG_AW  destination GPR (ignored for mul/div)
result  input  2*DATA_W  ALU result; [31:0] low/quotient, [63:32] high/remainder
wr_en  output  1  write strobe, one transfer per cycle
wr_sel  output  2  00 GPR, 01 LO, 10 HI
wr_addr  output  REG_AW  GPR address when wr_sel=00, else 0
wr_data  output  DATA_W  write data
done  output  1  one-cycle pulse on the final write of an op
op_err  output  1  one-cycle pulse: unsupported opcode accepted and dropped

Behaviour:
- Reset (clear=1, async): state=IDLE, Z latch=0, latched opcode=0, latched rd=0, wr_en=0, wr_sel=00, wr_addr=0, wr_data=0, done=0, op_err=0. in_ready=1 once clear deasserts.
- Handshake:
  - Transfer occurs on a rising edge with in_valid && in_ready.
  - Inputs are sampled only at that edge.
  - in_valid while in_ready=0 is ignored. The sender must hold its values.
- Opcode classes:
  - Single: and 00101, or 00110, add 00011, sub 00100, shl 01001, shr 00111, shra 01000, rol 01011, ror 01010, neg 10001, not 10010.
  - Double: mul 01111, div 10000.
  - Anything else: invalid.
- FSM states: IDLE, WR_GPR, WR_LO, WR_HI, ERR.
  - IDLE: in_ready=1, all strobes 0. On accept: Single -> WR_GPR; Double -> WR_LO; invalid -> ERR.
  - WR_GPR:
    - Outputs: wr_en=1, wr_sel=00, wr_addr=rd latch, wr_data=Z[31:0], done=1.
    - This is a last cycle (see overlap rule).
  - WR_LO:
    - Outputs: wr_en=1, wr_sel=01, wr_data=Z[31:0], done=0, in_ready=0.
    - Next state: WR_HI.
  - WR_HI:
    - Outputs: wr_en=1, wr_sel=10, wr_data=Z[63:32], done=1.
    - This is a last cycle.
  - ERR:
    - Outputs: op_err=1, wr_en=0, done=0.
    - This is a last cycle.
- Overlap rule:
  - in_ready=1 in IDLE and in every last cycle (WR_GPR, WR_HI, ERR).
  - An accept in a last cycle loads the new Z/opcode/rd and goes directly to that op's first state. There is no bubble.
  - With no accept, a last cycle returns to IDLE.
- Latency and throughput:
  - First write is asserted the cycle after the accept edge.
  - Single ops: one per cycle. Double ops: one per two cycles.
- All outputs are registered or decoded only from state and latches. There is no combinational path from inputs to outputs except none at all: in_ready depends on state only.
- Upper 32 bits of result are discarded for Single ops.
- Reset mid-operation aborts immediately. There is no partial HI write after a LO write. The next accept starts clean.

Decomposition:
- Shared package alu_pkg:
  - the 13 opcode localparams (identical values to the ALU select encoding);
  - wr_sel encodings WR_SEL_GPR/LO/HI;
  - state encoding.
- One natural sub-module: alu_op_class, a combinational opcode -> {single, double, invalid} decoder. The ALU's control path can reuse it.

Test Plan:
- Reset, then accept add, rd=5, result=64'h0000_0000_0000_0007 -> next cycle: wr_en=1, wr_sel=00, wr_addr=5, wr_data=7, done=1; then IDLE, wr_en=0.
- Accept mul, result=64'h0000_0001_FFFF_FFFE -> cycle+1: wr_sel=01, data FFFF_FFFE, in_ready=0; cycle+2: wr_sel=10, data 0000_0001, done=1.
- Accept div (quotient 3, remainder 1); in the WR_HI cycle accept or, rd=2, result=0xF0 -> LO=3, HI=1, then next cycle GPR2=0xF0 with no idle cycle between.
- Back-to-back add ops on 4 consecutive cycles, rd=1..4 -> 4 consecutive single-cycle writes; in_ready stays 1 throughout.
- Accept opcode 11111 -> cycle+1: op_err=1, wr_en=0; a valid op accepted in that cycle writes on the following cycle.
- Accept mul, assert clear during WR_LO -> all outputs 0 asynchronously, no HI write ever occurs; after release in_ready=1 and a new add completes normally.
